// File: rtl/regfile_pkg.sv
// Shared constants and types for the LEGv8 integer register file.
package regfile_pkg;

  localparam int XLEN       = 64;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_addr_t XZR_IDX = 5'd31;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: 31:1 mux over X0..X30, XZR reads as zero.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the addressed register is forwarded.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int NREGS = regfile_pkg::NREGS
) (
  input  logic [NREGS-2:0][XLEN-1:0] regs,
  input  reg_addr_t                  ra,
  input  logic                       we3,
  input  reg_addr_t                  wa3,
  input  logic [XLEN-1:0]            wd3,
  output logic [XLEN-1:0]            rd
);

  // An unmatched address (31, or X) falls through to zero.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NREGS - 1; i++) begin
      if (ra == reg_addr_t'(i)) begin
        rd = regs[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (we3 && (wa3 == ra) && (wa3 != XZR_IDX)) begin
      rd = wd3;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{we3, wa3, wd3};
`endif

endmodule

// File: rtl/regfile.sv
// 32 x 64-bit LEGv8 register file: two combinational reads, one clocked write, X31 = XZR.
// Optional write-through forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile
  import regfile_pkg::*;
#(
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int NREGS = regfile_pkg::NREGS
) (
  input  logic            clk,
  input  logic            we3,
  input  reg_addr_t       ra1,
  input  reg_addr_t       ra2,
  input  reg_addr_t       wa3,
  input  logic [XLEN-1:0] wd3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            reset
);

  // Storage exists only for X0..X30.
  logic [NREGS-2:0][XLEN-1:0] regs_q;
  logic [NREGS-2:0][XLEN-1:0] regs_d;
  logic                       wr_en;

  assign wr_en = we3 & ~reset;

  // A write to index 31 matches no entry and is dropped.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS - 1; i++) begin
      if (wr_en && (wa3 == reg_addr_t'(i))) begin
        regs_d[i] = wd3;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        regs_q[i] <= XLEN'(i);
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS)) u_rdport1 (
    .regs (regs_q),
    .ra   (ra1),
    .we3  (wr_en),
    .wa3  (wa3),
    .wd3  (wd3),
    .rd   (rd1)
  );

  regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS)) u_rdport2 (
    .regs (regs_q),
    .ra   (ra2),
    .we3  (wr_en),
    .wa3  (wa3),
    .wd3  (wd3),
    .rd   (rd2)
  );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: expected read data is queued when addresses are driven
// and popped when the read ports have settled.
module tb_regfile;
  import regfile_pkg::*;

  logic      clk;
  logic      reset;
  logic      we3;
  reg_addr_t ra1, ra2, wa3;
  xlen_t     wd3;
  xlen_t     rd1, rd2;

  int n_vec;
  int n_err;
  xlen_t exp_q[$];
  xlen_t model [31];

  regfile dut (
    .clk   (clk),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input xlen_t got, input xlen_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic xlen_t model_rd(input reg_addr_t a);
    return (a == XZR_IDX) ? '0 : model[a];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 31; i++) model[i] = xlen_t'(i);
  endfunction

  // Drive both read addresses, queue the expectations, then compare after settle.
  task automatic expect_rd(input string tag, input reg_addr_t a1, input reg_addr_t a2,
                           input xlen_t e1, input xlen_t e2);
    ra1 = a1;
    ra2 = a2;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    #1;
    check($sformatf("%s_rd1[x%0d]", tag, a1), rd1, exp_q.pop_front());
    check($sformatf("%s_rd2[x%0d]", tag, a2), rd2, exp_q.pop_front());
  endtask

  task automatic read_model(input string tag, input reg_addr_t a1, input reg_addr_t a2);
    expect_rd(tag, a1, a2, model_rd(a1), model_rd(a2));
  endtask

  task automatic do_write(input logic en, input reg_addr_t a, input xlen_t d);
    @(negedge clk);
    we3 = en;
    wa3 = a;
    wd3 = d;
    @(posedge clk);
    #1;
    if (en && a != XZR_IDX) model[a] = d;
    we3 = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    we3   = 1'b0;
    ra1   = '0;
    ra2   = '0;
    wa3   = '0;
    wd3   = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset values across the whole file, XZR on port 2
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      expect_rd("reset", reg_addr_t'(i), XZR_IDX, xlen_t'(i), '0);
    end

    // Basic write
    do_write(1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_rd("basic", 5'd10, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd11);

    // Write to XZR is discarded and disturbs nothing
    do_write(1'b1, XZR_IDX, 64'h1234);
    expect_rd("xzr", XZR_IDX, 5'd30, 64'd0, 64'd30);
    expect_rd("xzr_nb", 5'd0, 5'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Write disabled
    do_write(1'b0, 5'd5, 64'hDEAD);
    expect_rd("wedis", 5'd5, 5'd5, 64'd5, 64'd5);

    // Same-cycle read/write of X7
    @(negedge clk);
    we3 = 1'b1;
    wa3 = 5'd7;
    wd3 = 64'hA5A5;
`ifdef REGFILE_BYPASS_EN
    expect_rd("rw_pre", 5'd7, 5'd7, 64'hA5A5, 64'hA5A5);
`else
    expect_rd("rw_pre", 5'd7, 5'd7, 64'd7, 64'd7);
`endif
    @(posedge clk);
    #1;
    we3 = 1'b0;
    model[7] = 64'hA5A5;
    expect_rd("rw_post", 5'd7, 5'd8, 64'hA5A5, 64'd8);

    // Random writes (XZR included) checked against the model
    for (int n = 0; n < 24; n++) begin
      do_write(1'($urandom_range(0, 3) != 0), reg_addr_t'($urandom_range(0, 31)),
               {$urandom, $urandom});
    end
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      read_model("rand", reg_addr_t'($urandom_range(0, 31)), reg_addr_t'($urandom_range(0, 31)));
    end

    // Async reset between edges; a write attempted during reset is dropped
    do_write(1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF);
    do_write(1'b1, 5'd3, 64'h3333);
    expect_rd("pre_arst", 5'd10, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    expect_rd("arst", 5'd10, 5'd3, 64'd10, 64'd3);
    we3 = 1'b1;
    wa3 = 5'd3;
    wd3 = 64'h9999;
    @(posedge clk);
    #1;
    expect_rd("arst_wr", 5'd3, 5'd10, 64'd3, 64'd10);

    // First write lands on the first edge after reset falls
    @(negedge clk);
    reset = 1'b0;
    wa3 = 5'd4;
    wd3 = 64'h4444;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    model[4] = 64'h4444;
    expect_rd("post_rst", 5'd4, 5'd3, 64'h4444, 64'd3);

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      read_model("final", reg_addr_t'(i), reg_addr_t'(30 - i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
